// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM state encoding,
// default parameter values and idle levels of the SPI pins.
package spi_master_ctrl_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_SS_SETUP = 2;
  localparam int unsigned DEF_SS_HOLD  = 2;
  localparam int unsigned DEF_SS_GAP   = 2;

  // Mode 0: sclk idles low, slave select idles high (inactive).
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic SS_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_WAIT_NEXT,
    ST_HOLD,
    ST_GAP
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Byte-stream side of the SPI master: tx valid/ready handshake, rx pulse
// and busy status. The master modport is the upstream producer.
interface spi_master_ctrl_if
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              busy;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/spi_clk_gen.sv
// Saturating cycle counter: done is high while the count equals term, so a
// state that clears it on entry lasts term+1 cycles.
module spi_clk_gen #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    done  = (cnt_q == term);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: shifts stream words out on mosi MSB first, captures
// miso on sclk rises, and keeps ss low across words until tx_last completes.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned SS_SETUP = DEF_SS_SETUP,
  parameter int unsigned SS_HOLD  = DEF_SS_HOLD,
  parameter int unsigned SS_GAP   = DEF_SS_GAP
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_ctrl_if.slave bus,
  output logic             sclk,
  output logic             ss,
  output logic             mosi,
  input  logic             miso
);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam int unsigned PH_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned TMR_W = $clog2(max3(SS_SETUP, SS_HOLD, SS_GAP) + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              last_q, last_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              sclk_q, sclk_d;
  logic              ss_q, ss_d;
  logic              mosi_q, mosi_d;
  logic              accept, state_chg, phase_done, tmr_done;
  logic [TMR_W-1:0]  tmr_term;

  spi_clk_gen #(.CNT_W(PH_W)) u_phase (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_chg),
    .term (PH_W'(CLK_DIV - 1)),
    .done (phase_done)
  );

  spi_clk_gen #(.CNT_W(TMR_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_chg),
    .term (tmr_term),
    .done (tmr_done)
  );

  always_comb begin
    case (state_q)
      ST_SETUP: tmr_term = TMR_W'(SS_SETUP - 1);
      ST_HOLD:  tmr_term = TMR_W'(SS_HOLD - 1);
      default:  tmr_term = TMR_W'(SS_GAP - 1);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    accept     = bus.tx_valid && tx_ready_q;

    case (state_q)
      ST_IDLE, ST_WAIT_NEXT: begin
        if (accept) begin
          tx_shift_d = bus.tx_data;
          last_d     = bus.tx_last;
          bit_cnt_d  = BIT_W'(DATA_W - 1);
          mosi_d     = bus.tx_data[DATA_W-1];
          state_d    = (state_q == ST_IDLE) ? ST_SETUP : ST_LOW;
        end
      end
      ST_SETUP: if (tmr_done) state_d = ST_LOW;
      ST_LOW: begin
        if (phase_done) begin
          rx_shift_d = (rx_shift_q << 1) | DATA_W'(miso);
          state_d    = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (phase_done) begin
          if (bit_cnt_q == '0) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
            state_d    = last_q ? ST_HOLD : ST_WAIT_NEXT;
          end else begin
            bit_cnt_d  = bit_cnt_q - 1'b1;
            tx_shift_d = tx_shift_q << 1;
            mosi_d     = tx_shift_d[DATA_W-1];
            state_d    = ST_LOW;
          end
        end
      end
      ST_HOLD: if (tmr_done) state_d = ST_GAP;
      ST_GAP:  if (tmr_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pin-level outputs are decoded from the next state so they can all be
    // registered without lagging the state register by a cycle.
    state_chg  = (state_d != state_q);
    ss_d       = (state_d == ST_IDLE || state_d == ST_GAP) ? SS_IDLE : ~SS_IDLE;
    sclk_d     = (state_d == ST_HIGH) ? ~SCLK_IDLE : SCLK_IDLE;
    tx_ready_d = (state_d == ST_IDLE || state_d == ST_WAIT_NEXT);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      sclk_q     <= SCLK_IDLE;
      ss_q       <= SS_IDLE;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      last_q     <= last_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.busy     = busy_q;
  assign sclk         = sclk_q;
  assign ss           = ss_q;
  assign mosi         = mosi_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: loopback or fixed-response slave on miso,
// table vectors, randomized bursts and reset/WAIT_NEXT corner sequences.
module tb_spi_master_ctrl;
  localparam int W      = 8;
  localparam int DIV    = 2;
  localparam int SETUP  = 2;
  localparam int HOLD   = 2;
  localparam int GAP    = 2;
  localparam int T_RISE = SETUP + DIV;
  localparam int T_RX   = SETUP + 2 * W * DIV;
  localparam int T_SS   = T_RX + HOLD;
  localparam int T_RDY  = T_SS + GAP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk, ss, mosi, miso;

  spi_master_ctrl_if #(.DATA_W(W)) bus ();

  spi_master_ctrl #(
    .DATA_W  (W),
    .CLK_DIV (DIV),
    .SS_SETUP(SETUP),
    .SS_HOLD (HOLD),
    .SS_GAP  (GAP)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .sclk (sclk),
    .ss   (ss),
    .mosi (mosi),
    .miso (miso)
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Slave model: loopback, or a fixed word returned MSB first, one bit per sclk rise.
  logic       loopback = 1'b1;
  logic [7:0] slave_word = 8'h00;
  int         rise_cnt = 0, rise_base = 0, miso_idx;

  always_comb begin
    miso_idx = 7 - ((rise_cnt - rise_base) % 8);
    miso     = loopback ? mosi : slave_word[miso_idx[2:0]];
  end

  int         cyc = 0;
  int         ss_rise_n = 0, proto_err = 0;
  int         rx_cyc = 0, ss_rise_cyc = 0, rdy_cyc = 0, rise0_cyc = 0;
  logic [7:0] rx_got[$];
  logic       mosi_got[$];
  logic       sclk_p = 1'b0, ss_p = 1'b1, mosi_p = 1'b0, rdy_p = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (sclk === 1'b1 && sclk_p !== 1'b1) begin
      if (rise_cnt == rise_base) rise0_cyc = cyc;
      rise_cnt++;
      mosi_got.push_back(mosi);
    end
    if (sclk === 1'b1 && sclk_p === 1'b1 && mosi !== mosi_p) proto_err++;
    if (sclk === 1'b1 && ss !== 1'b0) proto_err++;
    if (ss === 1'b1 && ss_p === 1'b0) begin
      ss_rise_n++;
      ss_rise_cyc = cyc;
    end
    if (bus.rx_valid === 1'b1) begin
      rx_got.push_back(bus.rx_data);
      rx_cyc = cyc;
    end
    if (bus.tx_ready === 1'b1 && rdy_p !== 1'b1) rdy_cyc = cyc;
    sclk_p = sclk;
    ss_p   = ss;
    mosi_p = mosi;
    rdy_p  = bus.tx_ready;
  end

  int mosi_base = 0, rx_base = 0, ss_base = 0, err_base = 0;

  task automatic mark();
    rise_base = rise_cnt;
    mosi_base = mosi_got.size();
    rx_base   = rx_got.size();
    ss_base   = ss_rise_n;
    err_base  = proto_err;
  endtask

  // Returns the accept edge number (same numbering as cyc seen at negedge).
  task automatic send_word(input logic [7:0] d, input logic l, output int e0);
    int n;
    n = 0;
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_last  = l;
    while (bus.tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("handshake", (n < 200), 1);
    e0 = cyc + 1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    bus.tx_last  = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!(bus.tx_ready === 1'b1 && ss === 1'b1 && bus.busy === 1'b0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done"}, (k < 400), 1);
  endtask

  logic [7:0] send_q[$];
  logic [7:0] exp_q[$];

  task automatic run_burst(input string tag, input logic lp, input logic [7:0] slv,
                           input int max_gap);
    int         e0, e_first, n, idx;
    logic [7:0] b;
    mark();
    loopback   = lp;
    slave_word = slv;
    n          = send_q.size();
    e_first    = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      send_word(send_q[i], (i == n - 1), e0);
      if (i == 0) e_first = e0;
    end
    wait_done(tag);
    check($sformatf("%s rx_count", tag), rx_got.size() - rx_base, n);
    check($sformatf("%s rises", tag), mosi_got.size() - mosi_base, 8 * n);
    for (int i = 0; i < n; i++) begin
      idx = rx_base + i;
      b   = (idx < rx_got.size()) ? rx_got[idx] : 8'hxx;
      check($sformatf("%s rx_data[%0d]", tag, i), b, exp_q[i]);
      for (int j = 0; j < 8; j++) begin
        idx      = mosi_base + 8 * i + j;
        b[7 - j] = (idx < mosi_got.size()) ? mosi_got[idx] : 1'bx;
      end
      check($sformatf("%s mosi[%0d]", tag, i), b, send_q[i]);
    end
    check($sformatf("%s ss_rises", tag), ss_rise_n - ss_base, 1);
    check($sformatf("%s protocol", tag), proto_err - err_base, 0);
    if (n == 1) begin
      check($sformatf("%s t_rise0", tag), rise0_cyc - e_first, T_RISE);
      check($sformatf("%s t_rx", tag), rx_cyc - e_first, T_RX);
      check($sformatf("%s t_ss", tag), ss_rise_cyc - e_first, T_SS);
      check($sformatf("%s t_ready", tag), rdy_cyc - e_first, T_RDY);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       lp;
    logic [7:0] slv;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int e0, k, viol, n;
    logic       lp;
    logic [7:0] slv, w;

    vecs[0] = '{tx: 8'hA5, lp: 1'b1, slv: 8'h00, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'hAA, lp: 1'b0, slv: 8'h3C, exp_rx: 8'h3C};
    vecs[2] = '{tx: 8'h00, lp: 1'b1, slv: 8'hFF, exp_rx: 8'h00};
    vecs[3] = '{tx: 8'hFF, lp: 1'b0, slv: 8'h81, exp_rx: 8'h81};
    vecs[4] = '{tx: 8'h5A, lp: 1'b0, slv: 8'h00, exp_rx: 8'h00};
    vecs[5] = '{tx: 8'hC3, lp: 1'b1, slv: 8'h55, exp_rx: 8'hC3};

    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.tx_last  = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("reset ss", ss, 1);
    check("reset sclk", sclk, 0);
    check("reset mosi", mosi, 0);
    check("reset rx_valid", bus.rx_valid, 0);
    check("reset rx_data", bus.rx_data, 0);
    check("reset busy", bus.busy, 0);
    check("reset tx_ready", bus.tx_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("tx_ready after reset", bus.tx_ready, 1);

    foreach (vecs[i]) begin
      send_q = {vecs[i].tx};
      exp_q  = {vecs[i].exp_rx};
      run_burst($sformatf("vec%0d", i), vecs[i].lp, vecs[i].slv, 0);
    end

    send_q = {8'h01, 8'h80};
    exp_q  = {8'h01, 8'h80};
    run_burst("burst2", 1'b1, 8'h00, 0);

    // Hold in WAIT_NEXT with no new word offered.
    mark();
    loopback = 1'b1;
    send_word(8'h3C, 1'b0, e0);
    k = 0;
    while (rx_got.size() == rx_base && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("wait_next first rx", rx_got.size() - rx_base, 1);
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (ss !== 1'b0 || sclk !== 1'b0 || bus.tx_ready !== 1'b1 || bus.rx_valid !== 1'b0) viol++;
    end
    check("wait_next hold", viol, 0);
    send_word(8'hC3, 1'b1, e0);
    wait_done("wait_next");
    check("wait_next rx_count", rx_got.size() - rx_base, 2);
    w = (rx_got.size() > rx_base + 1) ? rx_got[rx_base + 1] : 8'hxx;
    check("wait_next second rx", w, 8'hC3);

    // Reset in the middle of a word.
    mark();
    loopback = 1'b1;
    send_word(8'hA5, 1'b1, e0);
    k = 0;
    while ((rise_cnt - rise_base) < 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid reached rise3", ((rise_cnt - rise_base) >= 3), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid ss", ss, 1);
    check("rst_mid sclk", sclk, 0);
    check("rst_mid rx_valid", bus.rx_valid, 0);
    check("rst_mid busy", bus.busy, 0);
    check("rst_mid tx_ready", bus.tx_ready, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_mid no rx", rx_got.size() - rx_base, 0);
    check("rst_mid ready", bus.tx_ready, 1);
    send_q = {8'h5A};
    exp_q  = {8'h5A};
    run_burst("rst_mid next", 1'b1, 8'h00, 0);

    // Randomized bursts; expected rx is the sent word (loopback) or the slave word.
    for (int t = 0; t < 15; t++) begin
      n   = $urandom_range(3, 1);
      lp  = 1'($urandom_range(1, 0));
      slv = 8'($urandom);
      send_q.delete();
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        w = 8'($urandom);
        send_q.push_back(w);
        exp_q.push_back(lp ? w : slv);
      end
      run_burst($sformatf("rand%0d", t), lp, slv, 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "time limit");
  end
endmodule
